// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster constants for the VGA timing chain
package vga_timing_pkg;

    localparam int COUNTER_W       = 10;
    localparam int CLK_DIV_DEFAULT = 4;

    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    // Sync pulse windows consumed by the downstream HSync/VSync generators
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;

    // Divider counter width; a single bit is kept even when no division is needed
    function automatic int div_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_counter_if.sv
// rtl/vga_timing_counter_if.sv - run control and raster position bundle of the VGA timebase
interface vga_timing_counter_if;
    import vga_timing_pkg::*;

    logic                 enable;
    logic [COUNTER_W-1:0] cntHorizontal;
    logic [COUNTER_W-1:0] cntVertical;
    logic                 pixTick;
    logic                 lineEnd;
    logic                 frameEnd;
    logic                 videoOn;

    modport master (
        input  enable,
        output cntHorizontal,
        output cntVertical,
        output pixTick,
        output lineEnd,
        output frameEnd,
        output videoOn
    );

    modport slave (
        output enable,
        input  cntHorizontal,
        input  cntVertical,
        input  pixTick,
        input  lineEnd,
        input  frameEnd,
        input  videoOn
    );

endinterface

// File: rtl/vga_timing_counter_divider.sv
// rtl/vga_timing_counter_divider.sv - system clock to pixel-rate enable divider
module pixel_tick_divider #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic pixTick
);
    import vga_timing_pkg::*;

    localparam int                DIV_W    = div_width(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (enable) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // With CLK_DIV=1 the counter is stuck at 0 == DIV_LAST, so the strobe follows enable
    assign pixTick = enable && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - horizontal/vertical raster counters driven by the pixel tick
module vga_timing_counter #(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV_DEFAULT,
    parameter int H_TOTAL   = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL   = vga_timing_pkg::V_TOTAL,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_timing_counter_if.master   tim
);
    import vga_timing_pkg::*;

    localparam logic [COUNTER_W-1:0] H_LAST = COUNTER_W'(H_TOTAL - 1);
    localparam logic [COUNTER_W-1:0] V_LAST = COUNTER_W'(V_TOTAL - 1);
    localparam logic [COUNTER_W-1:0] H_VIS  = COUNTER_W'(H_VISIBLE);
    localparam logic [COUNTER_W-1:0] V_VIS  = COUNTER_W'(V_VISIBLE);

    logic                 pix_tick;
    logic [COUNTER_W-1:0] h_cnt_q;
    logic [COUNTER_W-1:0] h_cnt_d;
    logic [COUNTER_W-1:0] v_cnt_q;
    logic [COUNTER_W-1:0] v_cnt_d;

    pixel_tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (tim.enable),
        .pixTick (pix_tick)
    );

    // Wrap by explicit compare so non-power-of-two totals never overshoot
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COUNTER_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + COUNTER_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign tim.cntHorizontal = h_cnt_q;
    assign tim.cntVertical   = v_cnt_q;
    assign tim.pixTick       = pix_tick;
    assign tim.lineEnd       = pix_tick && (h_cnt_q == H_LAST);
    assign tim.frameEnd      = tim.lineEnd && (v_cnt_q == V_LAST);
    assign tim.videoOn       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

endmodule

// File: tb/tb_vga_timing_counter.sv
// tb/tb_vga_timing_counter.sv - directed self-checking bench for vga_timing_counter
module tb_vga_timing_counter;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    int   checks = 0;
    int   errors = 0;

    vga_timing_counter_if if_a ();
    vga_timing_counter_if if_b ();
    vga_timing_counter_if if_c ();

    // a: full geometry /4, b: full geometry /1, c: shrunken 20x12 raster /4 for whole frames
    vga_timing_counter #(.CLK_DIV(4)) dut_a (.clk(clk), .rst_n(rst_a), .tim(if_a));
    vga_timing_counter #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_b), .tim(if_b));
    vga_timing_counter #(
        .CLK_DIV(4), .H_TOTAL(20), .V_TOTAL(12), .H_VISIBLE(16), .V_VISIBLE(10)
    ) dut_c (.clk(clk), .rst_n(rst_c), .tim(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input int h, input int v, input int lim, input string tag);
        int n = 0;
        while (!(int'(if_a.cntHorizontal) == h && int'(if_a.cntVertical) == v) && n < lim) begin
            step();
            n++;
        end
        chk(tag, (int'(if_a.cntHorizontal) == h && int'(if_a.cntVertical) == v) ? 1 : 0, 1);
    endtask

    task automatic wait_c(input int h, input int v, input int lim, input string tag);
        int n = 0;
        while (!(int'(if_c.cntHorizontal) == h && int'(if_c.cntVertical) == v) && n < lim) begin
            step();
            n++;
        end
        chk(tag, (int'(if_c.cntHorizontal) == h && int'(if_c.cntVertical) == v) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int lines;

        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        if_a.enable = 1'b1;
        if_b.enable = 1'b1;
        if_c.enable = 1'b1;
        repeat (3) step();

        chk("rst_h",        if_a.cntHorizontal, 0);
        chk("rst_v",        if_a.cntVertical,   0);
        chk("rst_video",    if_a.videoOn,       1);
        chk("rst_line",     if_a.lineEnd,       0);
        chk("rst_frame",    if_a.frameEnd,      0);
        chk("rst_tick_div4", if_a.pixTick,      0);
        chk("rst_tick_div1", if_b.pixTick,      1);

        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            chk($sformatf("tick_a_c%0d", cyc), if_a.pixTick, (cyc % 4 == 3) ? 1 : 0);
            chk($sformatf("h_a_c%0d", cyc),    if_a.cntHorizontal, cyc / 4);
            chk($sformatf("tick_b_c%0d", cyc), if_b.pixTick, 1);
            chk($sformatf("h_b_c%0d", cyc),    if_b.cntHorizontal, cyc);
            step();
        end

        wait_a(639, 10, 40000, "reach_639_10");
        chk("video_639", if_a.videoOn, 1);
        wait_a(640, 10, 8, "reach_640_10");
        chk("video_640", if_a.videoOn, 0);

        wait_a(799, 10, 1000, "reach_799_10");
        chk("video_799", if_a.videoOn, 0);
        chk("line_pre_tick", if_a.lineEnd, 0);
        n = 0;
        while (!if_a.pixTick && n < 8) begin
            step();
            n++;
        end
        chk("tick_at_799", if_a.pixTick, 1);
        chk("line_at_799", if_a.lineEnd, 1);
        chk("frame_at_799", if_a.frameEnd, 0);
        step();
        chk("wrap_h", if_a.cntHorizontal, 0);
        chk("wrap_v", if_a.cntVertical,   11);
        chk("wrap_line_clr", if_a.lineEnd, 0);

        wait_a(300, 11, 2000, "reach_300_11");
        step();
        if_a.enable = 1'b0;
        #1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            chk($sformatf("frz_h_%0d", cyc),    if_a.cntHorizontal, 300);
            chk($sformatf("frz_v_%0d", cyc),    if_a.cntVertical,   11);
            chk($sformatf("frz_tick_%0d", cyc), if_a.pixTick,       0);
            chk($sformatf("frz_line_%0d", cyc), if_a.lineEnd,       0);
            step();
        end
        if_a.enable = 1'b1;
        #1;
        // divider was frozen at phase 1, so the tick returns two cycles later
        for (int cyc = 0; cyc < 3; cyc++) begin
            chk($sformatf("resume_tick_%0d", cyc), if_a.pixTick, (cyc == 2) ? 1 : 0);
            step();
        end
        chk("resume_h", if_a.cntHorizontal, 301);

        wait_a(500, 11, 2000, "reach_500_11");
        step();
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        #1;
        chk("mrst_h",     if_a.cntHorizontal, 0);
        chk("mrst_v",     if_a.cntVertical,   0);
        chk("mrst_video", if_a.videoOn,       1);
        for (int cyc = 0; cyc < 4; cyc++) begin
            chk($sformatf("mrst_tick_%0d", cyc), if_a.pixTick, (cyc == 3) ? 1 : 0);
            step();
        end
        chk("mrst_h_after", if_a.cntHorizontal, 1);

        if_b.enable = 1'b0;
        #1;
        chk("div1_off_tick", if_b.pixTick, 0);
        chk("div1_off_line", if_b.lineEnd, 0);
        if_b.enable = 1'b1;

        rst_c = 1'b1;
        step();
        wait_c(15, 9, 2000, "reach_c_15_9");
        chk("c_video_15_9", if_c.videoOn, 1);
        wait_c(16, 9, 8, "reach_c_16_9");
        chk("c_video_16_9", if_c.videoOn, 0);
        wait_c(0, 10, 32, "reach_c_0_10");
        chk("c_video_0_10", if_c.videoOn, 0);
        wait_c(19, 11, 200, "reach_c_19_11");
        chk("c_video_19_11", if_c.videoOn, 0);
        chk("c_frame_pre_tick", if_c.frameEnd, 0);
        n = 0;
        while (!if_c.pixTick && n < 8) begin
            step();
            n++;
        end
        chk("c_line_end",  if_c.lineEnd,  1);
        chk("c_frame_end", if_c.frameEnd, 1);
        step();
        chk("c_frame_one_clk", if_c.frameEnd, 0);
        chk("c_wrap_h", if_c.cntHorizontal, 0);
        chk("c_wrap_v", if_c.cntVertical,   0);

        n = 1;
        lines = 0;
        while (!if_c.frameEnd && n < 3000) begin
            lines += int'(if_c.lineEnd);
            step();
            n++;
        end
        chk("c_frame_period", n, 20 * 12 * 4);
        chk("c_lines_between", lines, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
